vga_timing_generator: RTL and testbench

//  Produces raster scan position and sync for the 640x480@60 VGA output. Drives h_count/v_count

---
 rtl/vga_timing_generator_pkg.sv | 33 +++
 rtl/vga_timing_generator_sync_delay_line.sv | 35 +++
 rtl/vga_timing_generator.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_generator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_generator_pkg.sv
// Shared constants and state encodings for the 640x480@60 raster timing generator.
// The colour path reads the same values so both stay aligned.
package vga_timing_generator_pkg;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int MAX_TOTAL     = 1024;

    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FP  = 2'd1,
        H_SP  = 2'd2,
        H_BP  = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT = 2'd0,
        V_FP  = 2'd1,
        V_SP  = 2'd2,
        V_BP  = 2'd3
    } v_state_t;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_generator_sync_delay_line.sv
// CLK-rate shift register that delays a sync strobe by DEPTH cycles.
// Every stage resets asynchronously to RESET_VAL so no stale pulse survives a reset.
module vga_timing_generator_sync_delay_line #(
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0] stages;

            // Shift the raw sync level one stage per CLK
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stages <= {DEPTH{RESET_VAL}};
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stages[i] <= stages[i-1];
                    end
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// Raster position counters, horizontal/vertical phase FSMs and sync generation for VGA.
// All status outputs are registered from the next-count values so they match h_count/v_count.
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int   H_DISPLAY  = H_DISPLAY_DEF,
    parameter int   H_FRONT    = H_FRONT_DEF,
    parameter int   H_SYNC     = H_SYNC_DEF,
    parameter int   H_BACK     = H_BACK_DEF,
    parameter int   V_DISPLAY  = V_DISPLAY_DEF,
    parameter int   V_FRONT    = V_FRONT_DEF,
    parameter int   V_SYNC     = V_SYNC_DEF,
    parameter int   V_BACK     = V_BACK_DEF,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   CLK_DIV    = 1,
    parameter int   SYNC_DELAY = 1
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       pix_en,
    output logic       display_en,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank,
    output logic       VGA_HS,
    output logic       VGA_VS
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_DISP_W   = 10'(H_DISPLAY);
    localparam logic [9:0] H_ACT_LAST = 10'(H_DISPLAY - 1);
    localparam logic [9:0] H_FP_LAST  = 10'(H_DISPLAY + H_FRONT - 1);
    localparam logic [9:0] H_SP_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_DISP_W   = 10'(V_DISPLAY);
    localparam logic [9:0] V_ACT_LAST = 10'(V_DISPLAY - 1);
    localparam logic [9:0] V_FP_LAST  = 10'(V_DISPLAY + V_FRONT - 1);
    localparam logic [9:0] V_SP_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    generate
        if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
            $error("vga_timing_generator: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
            $error("vga_timing_generator: V_TOTAL exceeds 1024");
        end
    endgenerate

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    h_state_t         h_state;
    h_state_t         h_state_next;
    v_state_t         v_state;
    v_state_t         v_state_next;
    logic             hs_raw;
    logic             vs_raw;

    // Next divider and counter values; tick marks a CLK edge on which the raster advances
    always_comb begin
        tick     = (div == DIV_LAST);
        h_wrap   = tick && (h_count == H_LAST);
        v_wrap   = h_wrap && (v_count == V_LAST);
        div_next = div;
        h_next   = h_count;
        v_next   = v_count;
        if (tick) begin
            div_next = DIV_W'(0);
        end else begin
            div_next = div + DIV_W'(1);
        end
        if (!tick) begin
            h_next = h_count;
        end else if (h_wrap) begin
            h_next = 10'd0;
        end else begin
            h_next = h_count + 10'd1;
        end
        if (!h_wrap) begin
            v_next = v_count;
        end else if (v_wrap) begin
            v_next = 10'd0;
        end else begin
            v_next = v_count + 10'd1;
        end
    end

    // Counters and status flags, all derived from the values being loaded this edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div         <= DIV_W'(0);
            h_count     <= 10'd0;
            v_count     <= 10'd0;
            pix_en      <= 1'b0;
            display_en  <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
        end else begin
            div         <= div_next;
            h_count     <= h_next;
            v_count     <= v_next;
            pix_en      <= (div_next == DIV_LAST);
            display_en  <= (h_next < H_DISP_W) && (v_next < V_DISP_W);
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            vblank      <= (v_next >= V_DISP_W);
        end
    end

    // Phase state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else begin
            h_state <= h_state_next;
            v_state <= v_state_next;
        end
    end

    // Phase transitions fire on the edge that loads the first count of the next phase
    always_comb begin
        h_state_next = h_state;
        v_state_next = v_state;
        case (h_state)
            H_ACT:   if (tick && (h_count == H_ACT_LAST)) h_state_next = H_FP; else h_state_next = H_ACT;
            H_FP:    if (tick && (h_count == H_FP_LAST))  h_state_next = H_SP; else h_state_next = H_FP;
            H_SP:    if (tick && (h_count == H_SP_LAST))  h_state_next = H_BP; else h_state_next = H_SP;
            H_BP:    if (h_wrap)                          h_state_next = H_ACT; else h_state_next = H_BP;
            default: h_state_next = H_ACT;
        endcase
        case (v_state)
            V_ACT:   if (h_wrap && (v_count == V_ACT_LAST)) v_state_next = V_FP; else v_state_next = V_ACT;
            V_FP:    if (h_wrap && (v_count == V_FP_LAST))  v_state_next = V_SP; else v_state_next = V_FP;
            V_SP:    if (h_wrap && (v_count == V_SP_LAST))  v_state_next = V_BP; else v_state_next = V_SP;
            V_BP:    if (v_wrap)                            v_state_next = V_ACT; else v_state_next = V_BP;
            default: v_state_next = V_ACT;
        endcase
        hs_raw = sync_level(h_state == H_SP, SYNC_POL);
        vs_raw = sync_level(v_state == V_SP, SYNC_POL);
    end

    vga_timing_generator_sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (~SYNC_POL)
    ) u_hs_delay (
        .clk  (CLK),
        .rst  (RST),
        .din  (hs_raw),
        .dout (VGA_HS)
    );

    vga_timing_generator_sync_delay_line #(
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (~SYNC_POL)
    ) u_vs_delay (
        .clk  (CLK),
        .rst  (RST),
        .din  (vs_raw),
        .dout (VGA_VS)
    );

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboarded bench: full-size DUT (A), shrunken-geometry DUT (B) and CLK_DIV=2 DUT (C).
// Expectations are queued by cycle number; a negedge monitor pops and compares them.
module tb_vga_timing_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
    logic a_pix, a_de, a_ls, a_fs, a_vb, a_hs, a_vs;
    logic b_pix, b_de, b_ls, b_fs, b_vb, b_hs, b_vs;
    logic c_pix, c_de, c_ls, c_fs, c_vb, c_hs, c_vs;

    vga_timing_generator dut_a (
        .CLK(clk), .RST(rst), .h_count(a_h), .v_count(a_v), .pix_en(a_pix),
        .display_en(a_de), .line_start(a_ls), .frame_start(a_fs), .vblank(a_vb),
        .VGA_HS(a_hs), .VGA_VS(a_vs)
    );

    // H_TOTAL = 25 (sync h=18..21), V_TOTAL = 13 (sync lines 8,9), frame = 325 CLKs
    vga_timing_generator #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_b (
        .CLK(clk), .RST(rst), .h_count(b_h), .v_count(b_v), .pix_en(b_pix),
        .display_en(b_de), .line_start(b_ls), .frame_start(b_fs), .vblank(b_vb),
        .VGA_HS(b_hs), .VGA_VS(b_vs)
    );

    vga_timing_generator #(.CLK_DIV(2)) dut_c (
        .CLK(clk), .RST(rst), .h_count(c_h), .v_count(c_v), .pix_en(c_pix),
        .display_en(c_de), .line_start(c_ls), .frame_start(c_fs), .vblank(c_vb),
        .VGA_HS(c_hs), .VGA_VS(c_vs)
    );

    typedef enum int {
        A_H, A_V, A_PIX, A_DE, A_LS, A_FS, A_VB, A_HS, A_VS,
        B_H, B_V, B_PIX, B_DE, B_LS, B_FS, B_VB, B_HS, B_VS,
        C_H, C_V, C_PIX, C_DE, C_LS, C_FS, C_VB, C_HS, C_VS
    } field_t;

    typedef struct {
        int     at;
        field_t f;
        int     val;
    } item_t;

    item_t q[$];

    function automatic int get_val(input field_t f);
        case (f)
            A_H:   return int'(a_h);
            A_V:   return int'(a_v);
            A_PIX: return int'(a_pix);
            A_DE:  return int'(a_de);
            A_LS:  return int'(a_ls);
            A_FS:  return int'(a_fs);
            A_VB:  return int'(a_vb);
            A_HS:  return int'(a_hs);
            A_VS:  return int'(a_vs);
            B_H:   return int'(b_h);
            B_V:   return int'(b_v);
            B_PIX: return int'(b_pix);
            B_DE:  return int'(b_de);
            B_LS:  return int'(b_ls);
            B_FS:  return int'(b_fs);
            B_VB:  return int'(b_vb);
            B_HS:  return int'(b_hs);
            B_VS:  return int'(b_vs);
            C_H:   return int'(c_h);
            C_V:   return int'(c_v);
            C_PIX: return int'(c_pix);
            C_DE:  return int'(c_de);
            C_LS:  return int'(c_ls);
            C_FS:  return int'(c_fs);
            C_VB:  return int'(c_vb);
            C_HS:  return int'(c_hs);
            C_VS:  return int'(c_vs);
            default: return -1;
        endcase
    endfunction

    task automatic expect_at(input int at, input field_t f, input int val);
        item_t it;
        it.at  = at;
        it.f   = f;
        it.val = val;
        q.push_back(it);
    endtask

    // Rising edges since the last reset release; held at 0 while reset is asserted
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor: compare every queued expectation that falls due on this cycle
    always @(negedge clk) begin
        int i;
        int act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].at == cyc) begin
                act = get_val(q[i].f);
                total++;
                if (act != q[i].val) begin
                    bad++;
                    $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                             q[i].f.name(), cyc, act, q[i].val);
                end
                q.delete(i);
            end else if (q[i].at < cyc) begin
                total++;
                bad++;
                $display("FAIL %s missed at cycle %0d (now %0d)", q[i].f.name(), q[i].at, cyc);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        int guard;

        // Reset values (checked while reset is still asserted)
        expect_at(0, A_H, 0);   expect_at(0, A_V, 0);   expect_at(0, A_PIX, 0);
        expect_at(0, A_DE, 1);  expect_at(0, A_LS, 0);  expect_at(0, A_FS, 0);
        expect_at(0, A_VB, 0);  expect_at(0, A_HS, 1);  expect_at(0, A_VS, 1);
        // First cycles after release
        expect_at(1, A_H, 1);   expect_at(1, A_V, 0);   expect_at(1, A_PIX, 1);
        expect_at(2, A_PIX, 1); expect_at(1, A_LS, 0);  expect_at(1, A_FS, 0);
        // Full-size line: display edge, HS window 657..752, line wrap at 800
        expect_at(639, A_DE, 1); expect_at(640, A_DE, 0); expect_at(640, A_H, 640);
        expect_at(656, A_H, 656); expect_at(656, A_HS, 1); expect_at(657, A_HS, 0);
        expect_at(752, A_HS, 0); expect_at(753, A_HS, 1);
        expect_at(799, A_LS, 0); expect_at(800, A_LS, 1); expect_at(800, A_H, 0);
        expect_at(800, A_V, 1);  expect_at(800, A_FS, 0); expect_at(800, A_VS, 1);
        expect_at(801, A_LS, 0);
        // Small geometry: HS window, display_en corners, VS window, vblank, frame wrap
        expect_at(0, B_DE, 1);   expect_at(0, B_VB, 0);
        expect_at(18, B_HS, 1);  expect_at(19, B_HS, 0); expect_at(22, B_HS, 0); expect_at(23, B_HS, 1);
        expect_at(140, B_DE, 1); expect_at(141, B_DE, 0); expect_at(150, B_DE, 0);
        expect_at(149, B_VB, 0); expect_at(150, B_VB, 1);
        expect_at(200, B_VS, 1); expect_at(201, B_VS, 0); expect_at(250, B_VS, 0); expect_at(251, B_VS, 1);
        expect_at(300, B_FS, 0); expect_at(324, B_VB, 1); expect_at(324, B_FS, 0);
        expect_at(325, B_FS, 1); expect_at(325, B_LS, 1); expect_at(325, B_H, 0);
        expect_at(325, B_V, 0);  expect_at(325, B_DE, 1); expect_at(325, B_VB, 0);
        expect_at(326, B_FS, 0); expect_at(649, B_FS, 0); expect_at(650, B_FS, 1);
        // Just before the mid-frame reset: B inside both sync pulses
        expect_at(869, B_H, 19); expect_at(869, B_V, 8);
        expect_at(869, B_HS, 0); expect_at(869, B_VS, 0);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (870) @(posedge clk);
        #2 rst = 1'b1;

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL phase1_drain: got %0d pending, expected 0", q.size());
            q.delete();
        end

        // Checked during the reset just asserted: everything back to idle at once
        expect_at(0, B_H, 0); expect_at(0, B_V, 0); expect_at(0, B_HS, 1); expect_at(0, B_VS, 1);
        expect_at(0, A_H, 0); expect_at(0, C_PIX, 0); expect_at(0, C_HS, 1);
        // Counting resumes; no pulse on release
        expect_at(1, A_H, 1);  expect_at(1, B_FS, 0); expect_at(1, B_LS, 0);
        expect_at(26, B_H, 1); expect_at(26, B_V, 1);
        expect_at(325, B_FS, 1); expect_at(650, B_FS, 1);
        // CLK_DIV=2: strobe alternates, h advances every 2 CLKs, HS low for 192 CLKs
        expect_at(1, C_PIX, 1); expect_at(2, C_PIX, 0); expect_at(3, C_PIX, 1); expect_at(4, C_PIX, 0);
        expect_at(1, C_H, 0);   expect_at(2, C_H, 1);   expect_at(3, C_H, 1);   expect_at(4, C_H, 2);
        expect_at(1312, C_H, 656); expect_at(1312, C_HS, 1); expect_at(1313, C_HS, 0);
        expect_at(1504, C_HS, 0);  expect_at(1505, C_HS, 1);
        expect_at(1599, C_LS, 0);  expect_at(1600, C_LS, 1); expect_at(1600, C_H, 0);

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        guard = 0;
        while (q.size() > 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL phase2_timeout: got %0d pending, expected 0", q.size());
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
